dmem_preset_loader: RTL and testbench

Data memory for the i281 CPU that boots from the hardcoded DMEM preset block. After reset it copies the sixteen 8-bit preset words (b0I..b15I) into its 16x8 storage, one word per cycle. It then serves the CPU datapath as a synchronous one-read/one-write RAM. It sits directly downstream of the preset block and upstream of the register-file/ALU load path. A reload request re-runs the copy without a reset.

---
 rtl/dmem_preset_loader.sv | 106 ++++++++++
 tb/tb_dmem_preset_loader.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_preset_loader.sv
// 16x8 i281 data memory that copies the DMEM preset words into storage after
// reset or a reload request, then serves as a synchronous 1R/1W RAM.
module dmem_preset_loader #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic [DATA_W-1:0] b0I,
  input  logic [DATA_W-1:0] b1I,
  input  logic [DATA_W-1:0] b2I,
  input  logic [DATA_W-1:0] b3I,
  input  logic [DATA_W-1:0] b4I,
  input  logic [DATA_W-1:0] b5I,
  input  logic [DATA_W-1:0] b6I,
  input  logic [DATA_W-1:0] b7I,
  input  logic [DATA_W-1:0] b8I,
  input  logic [DATA_W-1:0] b9I,
  input  logic [DATA_W-1:0] b10I,
  input  logic [DATA_W-1:0] b11I,
  input  logic [DATA_W-1:0] b12I,
  input  logic [DATA_W-1:0] b13I,
  input  logic [DATA_W-1:0] b14I,
  input  logic [DATA_W-1:0] b15I,
  input  logic              reload,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              init_done
);

  typedef enum logic {INIT, READY} state_t;

  state_t              state, state_next;
  logic [ADDR_W-1:0]   cnt, cnt_next;
  logic                done_next;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem    [DEPTH];
  logic [DATA_W-1:0]   preset [DEPTH];

  assign preset = '{b0I, b1I, b2I, b3I, b4I, b5I, b6I, b7I,
                    b8I, b9I, b10I, b11I, b12I, b13I, b14I, b15I};

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= INIT;
      cnt       <= '0;
      init_done <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      init_done <= done_next;
    end
  end

  // The copy sequencer and the CPU port share one write port; INIT owns it.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    done_next  = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = wr_addr;
    mem_wdata  = wr_data;
    unique case (state)
      INIT: begin
        mem_we    = 1'b1;
        mem_waddr = cnt;
        mem_wdata = preset[cnt];
        cnt_next  = cnt + 1'b1;
        if (cnt == ADDR_W'(DEPTH - 1)) begin
          state_next = READY;
          cnt_next   = '0;
          done_next  = 1'b1;
        end
      end
      READY: begin
        mem_we = wr_en;
        if (reload) begin
          state_next = INIT;
          cnt_next   = '0;
        end
      end
      default: state_next = INIT;
    endcase
  end

  assign busy = (state == INIT);

  // Non-blocking read of mem gives read-before-write on an address collision.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
      if (mem_we) mem[mem_waddr] <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_dmem_preset_loader.sv
// Directed scoreboard bench for dmem_preset_loader: boot copy, RAM port,
// ignored INIT writes, reload, mid-copy reset and reload/write collision.
module tb_dmem_preset_loader;

  typedef struct {
    string      tag;
    logic [7:0] val;
  } exp_t;

  logic       Clock = 1'b0;
  logic       Reset_n;
  logic [7:0] b [16];
  logic       reload;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  logic       init_done;

  exp_t sb[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  dmem_preset_loader #(.DATA_W(8), .DEPTH(16), .ADDR_W(4)) dut (
    .Clock(Clock), .Reset_n(Reset_n),
    .b0I(b[0]), .b1I(b[1]), .b2I(b[2]), .b3I(b[3]),
    .b4I(b[4]), .b5I(b[5]), .b6I(b[6]), .b7I(b[7]),
    .b8I(b[8]), .b9I(b[9]), .b10I(b[10]), .b11I(b[11]),
    .b12I(b[12]), .b13I(b[13]), .b14I(b[14]), .b15I(b[15]),
    .reload(reload), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .init_done(init_done)
  );

  always #5 Clock = ~Clock;

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, passed=%0d total=%0d", pass_cnt, total_cnt);
    $fatal(1);
  end

  task automatic tick();
    @(posedge Clock);
    @(negedge Clock);
  endtask

  task automatic push(input string tag, input logic [7:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [7:0] obs);
    exp_t e;
    total_cnt++;
    if (sb.size() == 0) begin
      $error("FAIL scoreboard_empty: observed %0h, required an entry", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.val) pass_cnt++;
    else $error("FAIL %s: observed %0h required %0h", e.tag, obs, e.val);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] req);
    push(tag, req);
    pop_check(obs);
  endtask

  task automatic read_chk(input string tag, input logic [3:0] a, input logic [7:0] req);
    rd_addr = a;
    push(tag, req);
    tick();
    pop_check(rd_data);
  endtask

  initial begin
    Reset_n = 1'b0;
    reload  = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    rd_addr = 4'd1;
    for (int i = 0; i < 16; i++) b[i] = 8'h00;
    b[0] = 8'd7; b[1] = 8'd6; b[2] = 8'd5; b[3] = 8'd4; b[4] = 8'd3;

    // Reset state
    tick();
    tick();
    chk("rst_busy", {7'd0, busy}, 8'd1);
    chk("rst_done", {7'd0, init_done}, 8'd0);
    chk("rst_rd", rd_data, 8'h00);

    // Boot copy with an ignored write at INIT edge 5
    Reset_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      if (k == 5) begin
        wr_en = 1'b1; wr_addr = 4'd2; wr_data = 8'hFF;
      end
      tick();
      wr_en = 1'b0;
      if (k == 3) chk("boot_partial_rd", rd_data, 8'd6);
      if (k == 15) begin
        chk("boot_busy15", {7'd0, busy}, 8'd1);
        chk("boot_done15", {7'd0, init_done}, 8'd0);
      end
    end
    chk("boot_busy16", {7'd0, busy}, 8'd0);
    chk("boot_done16", {7'd0, init_done}, 8'd1);
    tick();
    chk("boot_done17", {7'd0, init_done}, 8'd0);

    read_chk("rd0", 4'd0, 8'd7);
    read_chk("rd1", 4'd1, 8'd6);
    read_chk("rd2_ignored_wr", 4'd2, 8'd5);
    read_chk("rd3", 4'd3, 8'd4);
    read_chk("rd4", 4'd4, 8'd3);
    read_chk("rd9", 4'd9, 8'd0);

    // Write with same-cycle read (old value), then new value
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 8'hA5;
    read_chk("rbw_old", 4'd3, 8'd4);
    wr_en = 1'b0;
    read_chk("wr_new", 4'd3, 8'hA5);

    // Reload overwrites a CPU write with the new preset
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 8'h11;
    tick();
    wr_en = 1'b0;
    b[0] = 8'h09;
    reload = 1'b1;
    tick();
    reload = 1'b0;
    chk("reload_busy", {7'd0, busy}, 8'd1);
    rd_addr = 4'd0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 1) chk("reload_rbw0", rd_data, 8'h11);
    end
    chk("reload_done", {7'd0, init_done}, 8'd1);
    read_chk("reload_rd0", 4'd0, 8'h09);

    // Reset at INIT cycle 8
    reload = 1'b1;
    tick();
    reload = 1'b0;
    rd_addr = 4'd1;
    for (int k = 1; k <= 8; k++) tick();
    chk("pre_rst_rd", rd_data, 8'd6);
    Reset_n = 1'b0;
    #1;
    chk("midrst_busy", {7'd0, busy}, 8'd1);
    chk("midrst_done", {7'd0, init_done}, 8'd0);
    chk("midrst_rd", rd_data, 8'h00);
    tick();
    tick();
    Reset_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 1) chk("midrst_mem_cleared", rd_data, 8'h00);
      if (k == 15) chk("midrst_done15", {7'd0, init_done}, 8'd0);
    end
    chk("midrst_done16", {7'd0, init_done}, 8'd1);
    tick();

    // Reload and write in the same cycle
    reload = 1'b1; wr_en = 1'b1; wr_addr = 4'd4; wr_data = 8'h22; rd_addr = 4'd4;
    tick();
    reload = 1'b0; wr_en = 1'b0;
    chk("coll_busy", {7'd0, busy}, 8'd1);
    chk("coll_rbw", rd_data, 8'd3);
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 1) chk("coll_written", rd_data, 8'h22);
      if (k == 5) chk("coll_before_copy", rd_data, 8'h22);
      if (k == 6) chk("coll_copied", rd_data, 8'd3);
    end
    chk("coll_done", {7'd0, init_done}, 8'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
